// File: rtl/uart_tx_press_if.sv
// Button-press UART transmitter bus: debounced switch level and data in, serial line and status out.
interface uart_tx_press_if;
   logic       i_Stable;
   logic [7:0] i_Data;
   logic       o_Tx_Serial;
   logic       o_Tx_Active;
   logic       o_Tx_Done;
   logic       o_Overrun;

   modport master (
      output i_Stable, i_Data,
      input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overrun
   );

   modport slave (
      input  i_Stable, i_Data,
      output o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overrun
   );
endinterface

// File: rtl/uart_tx_press.sv
// Sends one UART 8N1 frame per debounced rising edge of i_Stable, with a one-deep
// pending buffer for presses arriving mid-frame and a sticky overrun flag.
module uart_tx_press #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic            i_Clk,
   input  logic            i_Rst_n,
   uart_tx_press_if.slave  bus
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [7:0]       pend_byte_q, pend_byte_d;
   logic             pend_q, pend_d;
   logic             overrun_q, overrun_d;
   logic             done_q, done_d;
   logic             prev_stable_q, prev_stable_d;
   logic             press;
   logic             bit_end;
   logic             frame_end;
   logic             tx_serial;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q       <= IDLE;
         clk_cnt_q     <= '0;
         bit_idx_q     <= '0;
         tx_byte_q     <= '0;
         pend_byte_q   <= '0;
         pend_q        <= 1'b0;
         overrun_q     <= 1'b0;
         done_q        <= 1'b0;
         // Starting high means a switch held through reset release never fires.
         prev_stable_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_idx_q     <= bit_idx_d;
         tx_byte_q     <= tx_byte_d;
         pend_byte_q   <= pend_byte_d;
         pend_q        <= pend_d;
         overrun_q     <= overrun_d;
         done_q        <= done_d;
         prev_stable_q <= prev_stable_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      clk_cnt_d     = clk_cnt_q;
      bit_idx_d     = bit_idx_q;
      tx_byte_d     = tx_byte_q;
      pend_byte_d   = pend_byte_q;
      pend_d        = pend_q;
      overrun_d     = overrun_q;
      done_d        = 1'b0;
      prev_stable_d = bus.i_Stable;

      press     = bus.i_Stable & ~prev_stable_q;
      bit_end   = (clk_cnt_q == CNT_MAX);
      frame_end = (state_q == STOP) && bit_end;

      if (state_q == IDLE) begin
         clk_cnt_d = '0;
      end else begin
         clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            bit_idx_d = '0;
            if (press) begin
               tx_byte_d = bus.i_Data;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               // A buffered press has priority over one arriving on this very edge.
               if (pend_q) begin
                  tx_byte_d = pend_byte_q;
                  pend_d    = 1'b0;
                  state_d   = START;
                  if (press) begin
                     overrun_d = 1'b1;
                  end
               end else if (press) begin
                  tx_byte_d = bus.i_Data;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (press && (state_q != IDLE) && !frame_end) begin
         if (pend_q) begin
            overrun_d = 1'b1;
         end else begin
            pend_d      = 1'b1;
            pend_byte_d = bus.i_Data;
         end
      end
   end

   always_comb begin
      case (state_q)
         START:   tx_serial = 1'b0;
         DATA:    tx_serial = tx_byte_q[bit_idx_q];
         default: tx_serial = 1'b1;
      endcase
   end

   assign bus.o_Tx_Serial = tx_serial;
   assign bus.o_Tx_Active = (state_q != IDLE);
   assign bus.o_Tx_Done   = done_q;
   assign bus.o_Overrun   = overrun_q;
endmodule

// File: tb/tb_uart_tx_press.sv
// Bench for uart_tx_press: a frame-schedule model predicts line, active, done and overrun every cycle.
module tb_uart_tx_press;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_press_if bus();

   uart_tx_press #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: each accepted press becomes a scheduled frame (start edge, byte).
   int         fr_start[$];
   logic [7:0] fr_byte[$];
   logic       m_prev       = 1'b1;
   logic       m_pend       = 1'b0;
   int         m_pend_start = 0;
   int         m_last_end   = 0;
   logic       m_ovr        = 1'b0;

   function automatic logic [3:0] exp_out(int k);
      logic       line = 1'b1;
      logic       act  = 1'b0;
      logic       done = 1'b0;
      int         idx;
      logic [7:0] b;
      for (int i = 0; i < fr_start.size(); i++) begin
         if (k >= fr_start[i] && k < fr_start[i] + FRAME) begin
            act = 1'b1;
            idx = (k - fr_start[i]) / CPB;
            b   = fr_byte[i];
            if (idx == 0)      line = 1'b0;
            else if (idx <= 8) line = b[idx-1];
            else               line = 1'b1;
         end
         if (k == fr_start[i] + FRAME) done = 1'b1;
      end
      return {line, act, done, m_ovr};
   endfunction

   function automatic void model_edge(logic rn, logic s, logic [7:0] d);
      logic press;
      if (!rn) begin
         fr_start.delete();
         fr_byte.delete();
         m_pend     = 1'b0;
         m_ovr      = 1'b0;
         m_prev     = 1'b1;
         m_last_end = cyc;
         return;
      end
      press  = s & ~m_prev;
      m_prev = s;
      if (!press) return;
      if (m_pend && cyc > m_pend_start) m_pend = 1'b0;
      if (!m_pend && cyc >= m_last_end) begin
         fr_start.push_back(cyc);
         fr_byte.push_back(d);
         m_last_end = cyc + FRAME;
         $display("press cyc=%0d data=%h -> launch", cyc, d);
      end else if (!m_pend) begin
         fr_start.push_back(m_last_end);
         fr_byte.push_back(d);
         m_pend_start = m_last_end;
         m_last_end   = m_last_end + FRAME;
         m_pend       = 1'b1;
         $display("press cyc=%0d data=%h -> pending, starts cyc=%0d", cyc, d, m_pend_start);
      end else begin
         m_ovr = 1'b1;
         $display("press cyc=%0d data=%h -> dropped (overrun)", cyc, d);
      end
   endfunction

   function automatic logic [3:0] obs();
      return {bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Overrun};
   endfunction

   // Drive at the falling edge, let the DUT and model see the rising edge, return at the next falling edge.
   task automatic tick(input logic rn, input logic s, input logic [7:0] d);
      rst_n        = rn;
      bus.i_Stable = s;
      bus.i_Data   = d;
      @(posedge clk);
      cyc++;
      model_edge(rn, s, d);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] e;
      int         dones = 0;
      for (int i = 0; i < 23; i++) begin
         tick((i >= 3), 1'b1, 8'hC3);
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (bus.o_Tx_Done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL reset_done_count got=%0d want=0", dones);
      end
   endtask

   task automatic test_single();
      logic [3:0] e;
      int         dones = 0;
      int         act   = 0;
      tick(1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < FRAME + 10; i++) begin
         tick(1'b1, 1'b1, (i == 0) ? 8'hA5 : 8'($urandom));
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (bus.o_Tx_Done === 1'b1) dones++;
         if (bus.o_Tx_Active === 1'b1) act++;
      end
      total++;
      if (dones !== 1 || act !== FRAME) begin
         bad++;
         $display("FAIL single_counts done=%0d active=%0d want done=1 active=%0d", dones, act, FRAME);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e;
      logic [7:0] d;
      int         dones = 0;
      int         act   = 0;
      tick(1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         d = (i == 0) ? 8'hA5 : (i == 13) ? 8'h3C : 8'($urandom);
         tick(1'b1, (i < 3) || (i >= 13), d);
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (bus.o_Tx_Done === 1'b1) dones++;
         if (bus.o_Tx_Active === 1'b1) act++;
      end
      total++;
      if (dones !== 2 || act !== 2 * FRAME) begin
         bad++;
         $display("FAIL b2b_counts done=%0d active=%0d want done=2 active=%0d", dones, act, 2 * FRAME);
      end
   endtask

   task automatic test_overrun();
      logic [3:0] e;
      logic [7:0] d;
      int         dones = 0;
      tick(1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3 * FRAME; i++) begin
         d = (i == 0) ? 8'hA5 : (i == 13) ? 8'h3C : (i == 25) ? 8'hFF : 8'($urandom);
         tick(1'b1, (i < 3) || (i >= 13 && i < 20) || (i >= 25), d);
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL overrun cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (bus.o_Tx_Done === 1'b1) dones++;
      end
      total++;
      if (dones !== 2 || bus.o_Overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_final done=%0d ovr=%b want done=2 ovr=1", dones, bus.o_Overrun);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] e;
      int         dones = 0;
      tick(1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < FRAME + 20; i++) begin
         tick((i != 17), (i < 3) || (i >= 10 && i < 17), (i == 0) ? 8'h0F : 8'hAA);
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (i == 17) begin
            total++;
            if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0) begin
               bad++;
               $display("FAIL reset_mid_abort line=%b active=%b want line=1 active=0",
                        bus.o_Tx_Serial, bus.o_Tx_Active);
            end
         end
         if (i >= 17 && bus.o_Tx_Done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL reset_mid_done got=%0d want=0", dones);
      end
   endtask

   task automatic test_relevel();
      logic [3:0] e;
      int         dones = 0;
      tick(1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 160; i++) begin
         tick(1'b1, (i < 50) || (i >= 60), 8'h55);
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL relevel cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
         if (bus.o_Tx_Done === 1'b1) dones++;
      end
      total++;
      if (dones !== 2 || bus.o_Overrun !== 1'b0) begin
         bad++;
         $display("FAIL relevel_counts done=%0d ovr=%b want done=2 ovr=0", dones, bus.o_Overrun);
      end
   endtask

   task automatic test_random();
      logic [3:0] e;
      logic       s    = 1'b0;
      int         hold = 0;
      tick(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            s    = ~s;
            hold = $urandom_range(1, 60);
         end
         hold--;
         tick(($urandom_range(0, 399) != 0), s, 8'($urandom));
         e = exp_out(cyc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs(), e);
         end
      end
   endtask

   initial begin
      bus.i_Stable = 1'b1;
      bus.i_Data   = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_relevel();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
